spectrum_power: RTL and testbench
=================================

# spectrum_power

Converts a stream of complex FFT bins into per-bin power, averages it over 2^AVG_LOG2 consecutive frames, and buffers the averaged frame for a slower consumer. It sits directly upstream of the logarithmic dB-scaling stage, which takes an unsigned 24-bit linear power word. That stage is multi-cycle per sample, so output is released under a valid/ready handshake.

## Interface
- N_LOG2, default 8: log2 of bins per frame; legal range 2..10.
- AVG_LOG2, default 2: log2 of frames averaged; legal range 0..4.
- ipClk  input  1  clock; all logic on rising edge.
- ipReset  input  1  synchronous, active-high reset.
- ipReal  input  16  signed real part of bin.
- ipImag  input  16  signed imaginary part of bin.
- ipFirst  input  1  marks bin 0 of a frame; qualified by ipValid.
- ipValid  input  1  input bin valid. No back-pressure: the block accepts one bin every cycle.
- opOutput  output  24  averaged linear power, unsigned.
- opValid  output  1  opOutput valid; held until accepted.
- ipReady  input  1  consumer ready; a transfer occurs on a cycle with opValid && ipReady.
- opOverflow  output  1  sticky: a result was dropped because the buffer was full.

## Operation
- **Power:** p = ipReal² + ipImag², computed as a 32-bit unsigned value.
  - Scaled value s = p >> 7, saturated to 24'hFFFFFF. Only p = 2^31 (both inputs −32768) saturates.
- **Bin index:** counts 0..2^N_LOG2−1.
  - A valid bin with ipFirst loads index 0.
  - Each other valid bin increments the index.
  - Once index 2^N_LOG2−1 has been processed, further valid bins are ignored until the next ipFirst.
- **Sync:** after reset, valid bins are ignored until the first ipFirst.
- **Frame counter:** counts 0..2^AVG_LOG2−1.
  - It increments on each ipFirst that follows a complete frame.
  - An ipFirst arriving before a frame completes (short frame) clears the frame counter to 0. The partial average is discarded and no output is produced for it.
- **Accumulator RAM:** 2^N_LOG2 words of (24+AVG_LOG2) bits, read-modify-write per bin.
  - Frame 0 writes s, overwriting the word.
  - Later frames write acc + s.
- **Output:** in the last frame (count 2^AVG_LOG2−1), the block pushes (acc + s) >> AVG_LOG2 into the output FIFO instead of writing it back. Truncation, not rounding.
- **Output FIFO:** depth 2^N_LOG2.
  - A push while full is dropped and sets opOverflow.
  - opOverflow clears only on reset.
- **Order:** output words emerge in bin order 0..2^N_LOG2−1.
- **Reset mid-frame:** the bin index, frame counter, FIFO pointers, opValid and opOverflow all clear, and the block returns to waiting for ipFirst. RAM contents need no clearing, because frame 0 overwrites them.

## Timing
- **Reset values:** opValid=0, opOutput=0, opOverflow=0.
- **Pipeline** (one bin per cycle, fully pipelined):
  - Stage 1: register inputs, squares.
  - Stage 2: sum/scale/saturate, RAM read.
  - Stage 3: accumulate, RAM write or FIFO push.
- **Push latency:** a bin accepted on edge k is pushed into the FIFO on edge k+3.
- **RAM hazard:** consecutive bins use distinct addresses, so there is no hazard and no bypass is required. This relies on N_LOG2 ≥ 2.
- **FIFO to output:** a push into an empty FIFO raises opValid 2 edges after the push edge, so ipValid to opValid is 5 cycles.
  - opOutput and opValid are registered.
  - opOutput is stable while opValid && !ipReady.
- **Throughput:** with ipReady held high, back-to-back words are presented one per cycle; opValid stays high while the FIFO is non-empty.
- **Simultaneous push and pop when full:** the pop frees the slot, so the push succeeds and opOverflow does not set.
- **ipFirst while pipeline busy:** in-flight bins complete normally.

## Test plan
- **Basic average.** Stimulus: N_LOG2=2, AVG_LOG2=2, ipReady=1; 4 frames, all bins re=256, im=0 (p=65536, s=512). Required: exactly 4 words, each 0x000200, first opValid 5 cycles after the last frame's bin 0.
- **Saturation and scale.** Stimulus: AVG_LOG2=0. Bin 0 re=im=−32768; bin 1 re=32767, im=0; bin 2 re=im=0; bin 3 re=1, im=0. Required: 0xFFFFFF, 0x7FFE00, 0x000000, 0x000000.
- **Short-frame resync.**
  - Stimulus: frame 0 has only 2 bins, then ipFirst, then 4 full frames of s=512 (N_LOG2=2, AVG_LOG2=2).
  - Required: one frame of 4 words 0x000200; nothing is emitted for the partial sequence.
- **Back-pressure and overflow.**
  - Stimulus: ipReady=0 through two averaged frames.
  - Required: the first frame is buffered intact; the second frame is dropped; opOverflow=1. After ipReady=1, exactly 2^N_LOG2 words drain in order, with opOutput stable while stalled.
- **Reset mid-operation.**
  - Stimulus: pulse ipReset for 1 cycle during frame 1 with words pending.
  - Required: opValid=0 and opOverflow=0 the next cycle. Bins before the next ipFirst are ignored, and a fresh 4-frame average is correct.

Source files
------------

// File: rtl/spectrum_power.sv
// spectrum_power: per-bin |X|^2 scaled to 24 bits, averaged over 2^AVG_LOG2
// frames, and buffered in a FIFO for a valid/ready consumer.
module spectrum_power #(
    parameter int N_LOG2   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic [15:0] ipReal,
    input  logic [15:0] ipImag,
    input  logic        ipFirst,
    input  logic        ipValid,
    output logic [23:0] opOutput,
    output logic        opValid,
    input  logic        ipReady,
    output logic        opOverflow
);
    localparam int N  = 1 << N_LOG2;
    localparam int F  = 1 << AVG_LOG2;
    localparam int AW = 24 + AVG_LOG2;
    localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PW = N_LOG2 + 1;
    localparam logic [N_LOG2-1:0] IDX_LAST = N_LOG2'(N - 1);
    localparam logic [FW-1:0]     FRM_LAST = FW'(F - 1);
    localparam logic [PW-1:0]     OCC_FULL = PW'(N);

    // front end
    logic              sync_q, sync_d;
    logic [N_LOG2-1:0] idx_q, idx_d;
    logic [FW-1:0]     frm_q, frm_d;
    logic              take, complete;

    // pipeline
    logic               v1_q, v2_q, v3_q;
    logic [N_LOG2-1:0]  idx1_q, idx2_q, idx3_q;
    logic               fst1_q, fst2_q, fst3_q;
    logic               lst1_q, lst2_q, lst3_q;
    logic signed [15:0] re1_q, im1_q;
    logic signed [31:0] re_x, im_x;
    logic [31:0]        sqr2_q, sqi2_q, pwr;
    logic [23:0]        s_sat, s3_q, word;
    logic [AW-1:0]      acc3_q, sum;
    logic [AW-1:0]      ram_q [N];

    // FIFO and output register
    logic [23:0]   mem_q [N];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] occ_q, occ_d;
    logic          rvalid_q, rvalid_d;
    logic [23:0]   rdat_q, rdat_d;
    logic          vld_q, vld_d;
    logic [23:0]   dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic          push, push_ok, pop, out_load, fetch, wr_ram;

    assign complete = sync_q && (idx_q == IDX_LAST);

    // Bin index and frame counter for the bin on the input this cycle
    always_comb begin
        take   = 1'b0;
        sync_d = sync_q;
        idx_d  = idx_q;
        frm_d  = frm_q;
        if (ipValid && ipFirst) begin
            take   = 1'b1;
            sync_d = 1'b1;
            idx_d  = '0;
            if (!complete || frm_q == FRM_LAST)
                frm_d = '0;
            else
                frm_d = frm_q + 1'b1;
        end else if (ipValid && sync_q && !complete) begin
            take  = 1'b1;
            idx_d = idx_q + 1'b1;
        end
    end

    assign re_x   = 32'(re1_q);
    assign im_x   = 32'(im1_q);
    assign pwr    = sqr2_q + sqi2_q;
    // only p = 2^31 has bit 31 set; forcing all ones saturates it
    assign s_sat  = 24'((pwr >> 7) | {32{pwr[31]}});
    assign sum    = (fst3_q ? '0 : acc3_q) + AW'(s3_q);
    assign word   = 24'(sum >> AVG_LOG2);
    assign push   = v3_q && lst3_q;
    assign wr_ram = v3_q && !lst3_q;

    // FIFO bookkeeping; occupancy covers memory, read stage and output reg
    always_comb begin
        pop      = vld_q && ipReady;
        push_ok  = push && ((occ_q != OCC_FULL) || pop);
        out_load = !vld_q || ipReady;
        fetch    = (wr_ptr_q != rd_ptr_q) && (!rvalid_q || out_load);
        ovf_d    = ovf_q || (push && !push_ok);
        occ_d    = occ_q + PW'(push_ok) - PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(fetch);
        rvalid_d = fetch || (rvalid_q && !out_load);
        rdat_d   = fetch ? mem_q[rd_ptr_q[N_LOG2-1:0]] : rdat_q;
        vld_d    = out_load ? rvalid_q : vld_q;
        dout_d   = (out_load && rvalid_q) ? rdat_q : dout_q;
    end

    // Control state with synchronous reset
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            sync_q   <= 1'b0;
            idx_q    <= '0;
            frm_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rvalid_q <= 1'b0;
            vld_q    <= 1'b0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            idx_q    <= idx_d;
            frm_q    <= frm_d;
            v1_q     <= take;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rvalid_q <= rvalid_d;
            vld_q    <= vld_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Datapath, accumulator RAM and FIFO storage; qualified by valids
    always_ff @(posedge ipClk) begin
        re1_q  <= $signed(ipReal);
        im1_q  <= $signed(ipImag);
        idx1_q <= idx_d;
        fst1_q <= (frm_d == '0);
        lst1_q <= (frm_d == FRM_LAST);
        sqr2_q <= re_x * re_x;
        sqi2_q <= im_x * im_x;
        idx2_q <= idx1_q;
        fst2_q <= fst1_q;
        lst2_q <= lst1_q;
        s3_q   <= s_sat;
        acc3_q <= ram_q[idx2_q];
        idx3_q <= idx2_q;
        fst3_q <= fst2_q;
        lst3_q <= lst2_q;
        rdat_q <= rdat_d;
        if (wr_ram)
            ram_q[idx3_q] <= sum;
        if (push_ok)
            mem_q[wr_ptr_q[N_LOG2-1:0]] <= word;
    end

    assign opOutput   = dout_q;
    assign opValid    = vld_q;
    assign opOverflow = ovf_q;
endmodule

// File: tb/tb_spectrum_power.sv
// Bench for spectrum_power: directed scenarios with literal results plus a
// randomized run checked cycle by cycle against a frame-level model.
module tb_spectrum_power;
    localparam int NL = 2;
    localparam int AL = 2;
    localparam int N  = 1 << NL;
    localparam int F  = 1 << AL;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b1;
    logic [15:0] ipReal = '0;
    logic [15:0] ipImag = '0;
    logic        ipFirst = 1'b0;
    logic        ipValid = 1'b0;
    logic        ipReady = 1'b0;
    logic [23:0] opOutput;
    logic        opValid;
    logic        opOverflow;

    always #5 ipClk = ~ipClk;

    spectrum_power #(.N_LOG2(NL), .AVG_LOG2(AL)) dut (
        .ipClk(ipClk), .ipReset(ipReset), .ipReal(ipReal), .ipImag(ipImag),
        .ipFirst(ipFirst), .ipValid(ipValid), .opOutput(opOutput),
        .opValid(opValid), .ipReady(ipReady), .opOverflow(opOverflow)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit fv_arm = 0;
    int fv_edge = -1;
    int rdy_pct = 100;

    // model state
    longint m_acc [N];
    bit     m_sync, m_done, m_ovf;
    int     m_idx, m_frm;
    typedef struct { int t; logic [23:0] w; } ent_t;
    ent_t        pend[$];
    ent_t        q_m[$];
    logic [23:0] log_w[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] scale(input int re, input int im);
        longint p, s;
        p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        s = p / 128;
        if (s > 64'hFFFFFF) s = 64'hFFFFFF;
        return 24'(s);
    endfunction

    // Reference model: acts on every rising edge with pre-edge values
    always @(posedge ipClk) begin
        bit          xfer, take;
        logic [23:0] s;
        longint      prev;
        xfer = (opValid === 1'b1) && (ipReady === 1'b1);
        if (ipReset) begin
            pend.delete();
            q_m.delete();
            m_ovf = 0; m_sync = 0; m_done = 0; m_idx = 0; m_frm = 0;
        end else begin
            if (xfer && q_m.size() > 0) begin
                log_w.push_back(opOutput);
                void'(q_m.pop_front());
            end
            while (pend.size() > 0 && pend[0].t == cyc) begin
                if (q_m.size() < N) q_m.push_back('{cyc, pend[0].w});
                else m_ovf = 1;
                void'(pend.pop_front());
            end
            take = 0;
            if (ipValid && ipFirst) begin
                m_frm  = (m_sync && m_done) ? (m_frm + 1) % F : 0;
                m_sync = 1; m_done = 0; m_idx = 0; take = 1;
            end else if (ipValid && m_sync && !m_done) begin
                m_idx++; take = 1;
            end
            if (take) begin
                s = scale(int'($signed(ipReal)), int'($signed(ipImag)));
                prev = (m_frm == 0) ? 0 : m_acc[m_idx];
                if (m_frm == F - 1)
                    pend.push_back('{cyc + 3, 24'((prev + s) >> AL)});
                else
                    m_acc[m_idx] = prev + s;
                if (m_idx == N - 1) m_done = 1;
            end
        end
        cyc++;
    end

    // Compare process: outputs against the model on every falling edge
    always @(negedge ipClk) begin
        if (chk_en) begin
            chk("overflow", opOverflow, m_ovf);
            if (q_m.size() == 0) begin
                chk("valid_when_empty", opValid, 1'b0);
            end else begin
                if (q_m[0].t + 2 <= cyc - 1)
                    chk("valid_when_pending", opValid, 1'b1);
                if (opValid === 1'b1)
                    chk("data", opOutput, q_m[0].w);
            end
        end
        if (fv_arm && opValid === 1'b1) begin
            fv_edge = cyc - 1;
            fv_arm = 0;
        end
    end

    task automatic bin(input bit f, input int re, input int im);
        ipValid = 1'b1; ipFirst = f;
        ipReal = 16'(re); ipImag = 16'(im);
        @(posedge ipClk); #1;
        ipValid = 1'b0; ipFirst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge ipClk); #1; end
    endtask

    task automatic flat_frames(input int nf, input int re);
        for (int f = 0; f < nf; f++)
            for (int b = 0; b < N; b++) bin(b == 0, re, 0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q_m.size() != 0 || pend.size() != 0) && k < 200) begin
            @(posedge ipClk); #1; k++;
        end
        chk(name, 32'(k < 200), 32'd1);
        idle(3);
    endtask

    function automatic int rnd16();
        case ($urandom_range(0, 7))
            0: return -32768;
            1: return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic rbin(input bit f, input int re, input int im);
        ipReady = ($urandom_range(0, 99) < rdy_pct);
        bin(f, re, im);
    endtask

    initial begin
        logic [23:0] sat_exp [4];
        logic [23:0] bp_exp [4];
        int re_t [4];
        int im_t [4];
        int e0, len, mode;
        sat_exp = '{24'hFFFFFF, 24'h7FFE00, 24'h000000, 24'h000000};
        bp_exp  = '{24'h000200, 24'h000800, 24'h001200, 24'h002000};
        re_t = '{-32768, 32767, 0, 1};
        im_t = '{-32768, 0, 0, 0};

        // model pins
        chk("model_sat", scale(-32768, -32768), 24'hFFFFFF);
        chk("model_scale", scale(32767, 0), 24'h7FFE00);
        chk("model_small", scale(256, 0), 24'h000200);

        // reset values
        idle(3);
        chk("rst_valid", opValid, 1'b0);
        chk("rst_output", opOutput, 24'h0);
        chk("rst_overflow", opOverflow, 1'b0);
        ipReset = 1'b0;
        chk_en = 1;
        ipReady = 1'b1;

        // basic average and latency
        log_w.delete();
        fv_arm = 1;
        e0 = 0;
        for (int f = 0; f < F; f++)
            for (int b = 0; b < N; b++) begin
                if (f == F - 1 && b == 0) e0 = cyc;
                bin(b == 0, 256, 0);
            end
        drain("t1_drain");
        chk("t1_count", log_w.size(), N);
        foreach (log_w[i]) chk("t1_word", log_w[i], 24'h000200);
        chk("t1_latency", fv_edge - e0, 5);

        // saturation and scale
        log_w.delete();
        for (int f = 0; f < F; f++)
            for (int b = 0; b < N; b++) bin(b == 0, re_t[b], im_t[b]);
        drain("t2_drain");
        chk("t2_count", log_w.size(), N);
        foreach (log_w[i]) chk("t2_word", log_w[i], sat_exp[i]);

        // short-frame resync
        log_w.delete();
        bin(1, 256, 0);
        bin(0, 256, 0);
        flat_frames(F, 256);
        drain("t3_drain");
        chk("t3_count", log_w.size(), N);
        foreach (log_w[i]) chk("t3_word", log_w[i], 24'h000200);

        // back-pressure and overflow
        log_w.delete();
        ipReady = 1'b0;
        for (int f = 0; f < F; f++)
            for (int b = 0; b < N; b++) bin(b == 0, 256 * (b + 1), 0);
        for (int f = 0; f < F; f++)
            for (int b = 0; b < N; b++) bin(b == 0, 128 * (b + 1), 0);
        idle(8);
        chk("t4_overflow", opOverflow, 1'b1);
        chk("t4_stall_valid", opValid, 1'b1);
        chk("t4_stall_head", opOutput, 24'h000200);
        idle(6);
        chk("t4_stall_hold", opOutput, 24'h000200);
        ipReady = 1'b1;
        drain("t4_drain");
        chk("t4_count", log_w.size(), N);
        foreach (log_w[i]) chk("t4_word", log_w[i], bp_exp[i]);

        // reset mid-operation with words pending
        ipReady = 1'b0;
        flat_frames(F, 256);
        flat_frames(1, 256);
        bin(1, 256, 0);
        bin(0, 256, 0);
        idle(2);
        chk("t5_pending", opValid, 1'b1);
        ipReset = 1'b1;
        idle(1);
        ipReset = 1'b0;
        chk("t5_rst_valid", opValid, 1'b0);
        chk("t5_rst_overflow", opOverflow, 1'b0);
        log_w.delete();
        ipReady = 1'b1;
        for (int b = 0; b < 3; b++) bin(0, 1000, 1000);
        flat_frames(F, 512);
        drain("t5_drain");
        chk("t5_count", log_w.size(), N);
        foreach (log_w[i]) chk("t5_word", log_w[i], 24'h000800);

        // randomized run
        for (int fr = 0; fr < 160; fr++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) len = $urandom_range(1, N - 1);
            else if (mode == 1) len = N + $urandom_range(1, 2);
            else len = N;
            rdy_pct = ((fr % 32) < 10) ? 15 : 85;
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 7) == 0) begin
                    ipFirst = 1'(($urandom_range(0, 1)));
                    ipReady = ($urandom_range(0, 99) < rdy_pct);
                    idle(1);
                    ipFirst = 1'b0;
                end
                rbin(b == 0, rnd16(), rnd16());
            end
        end
        ipReady = 1'b1;
        drain("rand_drain");
        chk("rand_empty", q_m.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
